rename_freelist_ctrl: RTL and testbench
=======================================

// Module: rename_freelist_ctrl
// PURPOSE
//  Physical-register free-list and branch-checkpoint controller for the Rename stage.
//  - Hands one free PREG per cycle to Rename and accepts one committed PREG per cycle back from the ROB.
//  - Snapshots the allocation pointer when a branch is renamed, so a mispredict restores the free list in one cycle.
// PARAMETERS
//  N_LOG      32  architectural registers; PREGs 0..N_LOG-1 are the initial map, never in the list at reset
//  N_PHYS     64  physical registers; FL_DEPTH=N_PHYS-N_LOG must be a power of 2
//  N_CHECKPTS 8   branch snapshot slots; must be a power of 2
//  (derived) PREG_W=$clog2(N_PHYS), PTR_W=$clog2(FL_DEPTH)+1, CK_W=$clog2(N_CHECKPTS)
// PORTS
//  clk            in  1      clock, all state on posedge
//  rst_n          in  1      asynchronous, active-low reset
//  alloc_req_i    in  1      Rename needs a new PREG this cycle
//  alloc_gnt_o    out 1      =alloc_req_i & ~empty_o; allocation fires when high
//  alloc_preg_o   out PREG_W PREG at head; valid whenever ~empty_o
//  free_valid_i   in  1      ROB commit returns a PREG
//  free_preg_i    in  PREG_W PREG being returned
//  ckpt_save_i    in  1      snapshot request (branch renamed)
//  ckpt_id_o      out CK_W   slot the snapshot is written to (current ckpt tail)
//  ckpt_avail_o   out 1      a checkpoint slot is free
//  ckpt_release_i in  1      oldest checkpoint retires (branch resolved correct)
//  recover_i      in  1      mispredict; restore from recover_id_i
//  recover_id_i   in  CK_W   checkpoint to restore
//  free_count_o   out PTR_W  entries currently in the free list
//  empty_o        out 1      free_count_o==0
//  err_o          out 1      sticky: overflow free, save with no slot, or recover/release with no live checkpoint
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - Array entry i = N_LOG+i; head=0; tail=FL_DEPTH (wrap bit set, list full).
//  - Outputs: free_count_o=FL_DEPTH, alloc_preg_o=N_LOG, empty_o=0, alloc_gnt_o=0 (req low).
//  - Checkpoint head/tail=0, ckpt_count=0, ckpt_avail_o=1, ckpt_id_o=0, err_o=0.
//  - Reset mid-operation discards all allocations and snapshots.
//  Free list: circular array, PTR_W-bit pointers with wrap bit; free_count_o=tail-head (modulo 2^PTR_W).
//  Alloc: on alloc_gnt_o, head+=1 at posedge. alloc_preg_o is combinational from array[head]; zero cycles of latency.
//  Free: on free_valid_i, array[tail]=free_preg_i, tail+=1.
//  - free_preg_i==0 (x0 PREG) is ignored.
//  - Free while free_count_o==FL_DEPTH is dropped and sets err_o.
//  Alloc and free in the same cycle: both apply; count unchanged. Empty + free: no grant this cycle, entry visible next cycle.
//  Save: when ckpt_save_i & ckpt_avail_o, snap[ckpt_tail] = head + (alloc_gnt_o ? 1 : 0).
//  - The snapshot includes the branch's own same-cycle allocation.
//  - ckpt_tail+=1, ckpt_count+=1. Save with ~ckpt_avail_o sets err_o, no state change.
//  Release: ckpt_release_i with ckpt_count>0 advances ckpt_head and decrements ckpt_count. With count 0 it sets err_o.
//  Recover (highest priority):
//  - head = snap[recover_id_i]; ckpt_tail = recover_id_i+1, so younger checkpoints are discarded.
//  - ckpt_count = ckpt_tail_new - ckpt_head. The recovered slot is kept until its release.
//  - Same-cycle alloc_req_i and ckpt_save_i are ignored; alloc_gnt_o is forced 0.
//  - Same-cycle free_valid_i still applies to tail; same-cycle ckpt_release_i still applies.
//  - recover_id_i outside the live range [ckpt_head, ckpt_tail) sets err_o and is otherwise ignored.
//  Invariant: head never passes tail. Every pointer wraps modulo its depth with no special-casing.
// TESTING
//  1 Reset, alloc_req_i=1 for 3 cycles -> alloc_preg_o 32,33,34; free_count_o 32->29.
//  2 Alloc 32 times back-to-back -> empty_o=1 after the 32nd, alloc_gnt_o=0. Then free 40 -> next cycle alloc_preg_o=40, count=1.
//  3 Alloc+free same cycle at count=5 (free 50) -> count stays 5, 50 written at tail. Free 0 -> ignored, count unchanged.
//  4 Alloc 32,33; save+alloc(34) -> ckpt_id_o=0; alloc 35,36; recover id 0 -> count back to the post-34 value, next alloc_preg_o=35.
//  5 Save 8 checkpoints -> ckpt_avail_o=0; 9th save -> err_o=1. Release 1 -> ckpt_avail_o=1, next ckpt_id_o=0 (wrap).
//  6 Save ids 0,1,2; recover id 1 with free_valid_i (preg 45) same cycle -> ckpt_count=2, 45 enqueued, alloc_gnt_o=0; rst_n low mid-run -> reset values.

Source files
------------

// File: rtl/rename_freelist_ctrl.sv
// Physical-register free list for Rename, with branch checkpoints that snapshot the
// allocation pointer so a mispredict can restore the list in a single cycle.
module rename_freelist_ctrl #(
    parameter int unsigned N_LOG      = 32,
    parameter int unsigned N_PHYS     = 64,
    parameter int unsigned N_CHECKPTS = 8,
    localparam int unsigned FL_DEPTH  = N_PHYS - N_LOG,
    localparam int unsigned PREG_W    = $clog2(N_PHYS),
    localparam int unsigned PTR_W     = $clog2(FL_DEPTH) + 1,
    localparam int unsigned CK_W      = $clog2(N_CHECKPTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [PREG_W-1:0] alloc_preg_o,
    input  logic              free_valid_i,
    input  logic [PREG_W-1:0] free_preg_i,
    input  logic              ckpt_save_i,
    output logic [CK_W-1:0]   ckpt_id_o,
    output logic              ckpt_avail_o,
    input  logic              ckpt_release_i,
    input  logic              recover_i,
    input  logic [CK_W-1:0]   recover_id_i,
    output logic [PTR_W-1:0]  free_count_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int unsigned IDX_W = PTR_W - 1;

    logic [PREG_W-1:0] fl_q   [FL_DEPTH];
    logic [PREG_W-1:0] fl_d   [FL_DEPTH];
    logic [PTR_W-1:0]  snap_q [N_CHECKPTS];
    logic [PTR_W-1:0]  snap_d [N_CHECKPTS];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CK_W-1:0]  ckpt_head_q, ckpt_head_d;
    logic [CK_W-1:0]  ckpt_tail_q, ckpt_tail_d;
    logic [CK_W:0]    ckpt_count_q, ckpt_count_d;
    logic             err_q, err_d;

    logic             full;
    logic             free_nonzero;
    logic             free_fire;
    logic             save_fire;
    logic             rel_fire;
    logic             rec_live;
    logic             rec_ok;
    logic [CK_W-1:0]  rec_dist;
    logic [CK_W:0]    ckpt_count_base;

    assign free_count_o = tail_q - head_q;
    assign empty_o      = (free_count_o == '0);
    assign full         = (free_count_o == PTR_W'(FL_DEPTH));
    assign alloc_preg_o = fl_q[head_q[IDX_W-1:0]];
    assign alloc_gnt_o  = alloc_req_i & ~empty_o & ~recover_i;

    assign ckpt_avail_o = (ckpt_count_q < (CK_W+1)'(N_CHECKPTS));
    assign ckpt_id_o    = ckpt_tail_q;
    assign err_o        = err_q;

    // Live slots are the ckpt_count_q entries starting at ckpt_head_q (modulo depth).
    assign rec_dist = recover_id_i - ckpt_head_q;
    assign rec_live = ({1'b0, rec_dist} < ckpt_count_q);
    assign rec_ok   = recover_i & rec_live;

    assign free_nonzero = (free_preg_i != '0);
    assign free_fire    = free_valid_i & free_nonzero & ~full;
    assign save_fire    = ckpt_save_i & ckpt_avail_o & ~recover_i;
    assign rel_fire     = ckpt_release_i & (ckpt_count_q != '0);

    always_comb begin
        fl_d = fl_q;
        tail_d = tail_q;
        if (free_fire) begin
            fl_d[tail_q[IDX_W-1:0]] = free_preg_i;
            tail_d = tail_q + PTR_W'(1);
        end
    end

    always_comb begin
        snap_d = snap_q;
        head_d = head_q + PTR_W'(alloc_gnt_o);
        ckpt_tail_d = ckpt_tail_q;
        ckpt_count_base = ckpt_count_q;
        if (rec_ok) begin
            head_d = snap_q[recover_id_i];
            ckpt_tail_d = recover_id_i + CK_W'(1);
            ckpt_count_base = {1'b0, rec_dist} + (CK_W+1)'(1);
        end else if (save_fire) begin
            // Snapshot covers the branch's own same-cycle allocation.
            snap_d[ckpt_tail_q] = head_q + PTR_W'(alloc_gnt_o);
            ckpt_tail_d = ckpt_tail_q + CK_W'(1);
            ckpt_count_base = ckpt_count_q + (CK_W+1)'(1);
        end
        ckpt_head_d  = ckpt_head_q + CK_W'(rel_fire);
        ckpt_count_d = ckpt_count_base - (CK_W+1)'(rel_fire);
    end

    always_comb begin
        err_d = err_q;
        if (free_valid_i && free_nonzero && full)      err_d = 1'b1;
        if (ckpt_save_i && !recover_i && !ckpt_avail_o) err_d = 1'b1;
        if (ckpt_release_i && (ckpt_count_q == '0))    err_d = 1'b1;
        if (recover_i && !rec_live)                    err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FL_DEPTH); i++) begin
                fl_q[i] <= PREG_W'(N_LOG + i);
            end
            for (int i = 0; i < int'(N_CHECKPTS); i++) begin
                snap_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= PTR_W'(FL_DEPTH);
            ckpt_head_q  <= '0;
            ckpt_tail_q  <= '0;
            ckpt_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            fl_q         <= fl_d;
            snap_q       <= snap_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            ckpt_head_q  <= ckpt_head_d;
            ckpt_tail_q  <= ckpt_tail_d;
            ckpt_count_q <= ckpt_count_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Self-checking bench for rename_freelist_ctrl: directed scenarios plus random traffic,
// all compared against an unbounded-counter reference model of the free list.
module tb_rename_freelist_ctrl;

    localparam int N_LOG = 32;
    localparam int N_PHYS = 64;
    localparam int N_CK = 8;
    localparam int DEPTH = N_PHYS - N_LOG;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req_i, free_valid_i, ckpt_save_i, ckpt_release_i, recover_i;
    logic [5:0] free_preg_i;
    logic [2:0] recover_id_i;
    logic       alloc_gnt_o, ckpt_avail_o, empty_o, err_o;
    logic [5:0] alloc_preg_o, free_count_o;
    logic [2:0] ckpt_id_o;

    rename_freelist_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req_i   (alloc_req_i),
        .alloc_gnt_o   (alloc_gnt_o),
        .alloc_preg_o  (alloc_preg_o),
        .free_valid_i  (free_valid_i),
        .free_preg_i   (free_preg_i),
        .ckpt_save_i   (ckpt_save_i),
        .ckpt_id_o     (ckpt_id_o),
        .ckpt_avail_o  (ckpt_avail_o),
        .ckpt_release_i(ckpt_release_i),
        .recover_i     (recover_i),
        .recover_id_i  (recover_id_i),
        .free_count_o  (free_count_o),
        .empty_o       (empty_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: monotonic head/tail counters, ring storage indexed modulo depth.
    int m_head, m_tail, ck_head, ck_tail;
    int m_fl[DEPTH];
    int m_snap[N_CK];
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_head = 0;
        m_tail = DEPTH;
        ck_head = 0;
        ck_tail = 0;
        m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_fl[i] = N_LOG + i;
        for (int i = 0; i < N_CK; i++) m_snap[i] = 0;
    endtask

    task automatic idle();
        alloc_req_i = 0; free_valid_i = 0; free_preg_i = 0; ckpt_save_i = 0;
        ckpt_release_i = 0; recover_i = 0; recover_id_i = 0;
    endtask

    task automatic check_reset();
        check_eq("rst_count", free_count_o, DEPTH);
        check_eq("rst_preg", alloc_preg_o, N_LOG);
        check_eq("rst_empty", empty_o, 0);
        check_eq("rst_gnt", alloc_gnt_o, 0);
        check_eq("rst_avail", ckpt_avail_o, 1);
        check_eq("rst_ckid", ckpt_id_o, 0);
        check_eq("rst_err", err_o, 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic bit ck_live(input int id, output int k_out);
        k_out = -1;
        for (int k = ck_head; k < ck_tail; k++) if (k % N_CK == id) k_out = k;
        return k_out >= 0;
    endfunction

    // Inputs are already applied; compare outputs, advance the model, then clock.
    task automatic tick();
        int cnt, ckc, k;
        bit gnt, live;
        #1;
        cnt = m_tail - m_head;
        ckc = ck_tail - ck_head;
        gnt = alloc_req_i && cnt != 0 && !recover_i;
        check_eq("gnt", alloc_gnt_o, gnt);
        check_eq("count", free_count_o, cnt);
        check_eq("empty", empty_o, cnt == 0);
        if (cnt != 0) check_eq("preg", alloc_preg_o, m_fl[m_head % DEPTH]);
        check_eq("avail", ckpt_avail_o, ckc < N_CK);
        check_eq("ckid", ckpt_id_o, ck_tail % N_CK);
        check_eq("err", err_o, m_err);

        live = ck_live(int'(recover_id_i), k);
        if (free_valid_i && free_preg_i != 0 && cnt == DEPTH) m_err = 1;
        if (ckpt_save_i && !recover_i && ckc >= N_CK) m_err = 1;
        if (ckpt_release_i && ckc == 0) m_err = 1;
        if (recover_i && !live) m_err = 1;

        if (free_valid_i && free_preg_i != 0 && cnt < DEPTH) begin
            m_fl[m_tail % DEPTH] = int'(free_preg_i);
            m_tail++;
        end
        if (recover_i && live) begin
            m_head = m_snap[recover_id_i];
            ck_tail = k + 1;
        end else begin
            if (ckpt_save_i && !recover_i && ckc < N_CK) begin
                m_snap[ck_tail % N_CK] = m_head + int'(gnt);
                ck_tail++;
            end
            if (gnt) m_head++;
        end
        if (ckpt_release_i && ckc > 0) ck_head++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int k;
        idle();
        @(negedge clk);
        do_reset();

        // Three back-to-back allocations from reset.
        for (int i = 0; i < 3; i++) begin
            alloc_req_i = 1;
            #1 check_eq("t1_preg", alloc_preg_o, 32 + i);
            tick();
        end
        idle();
        #1 check_eq("t1_count", free_count_o, 29);

        // Drain to empty, then free into an empty list.
        alloc_req_i = 1;
        for (int i = 0; i < 29; i++) tick();
        #1 check_eq("t2_empty", empty_o, 1);
        check_eq("t2_gnt", alloc_gnt_o, 0);
        free_valid_i = 1; free_preg_i = 40;
        tick();
        idle();
        #1 check_eq("t2_preg", alloc_preg_o, 40);
        check_eq("t2_count", free_count_o, 1);

        // Build count 5, then simultaneous alloc+free, then free of x0.
        for (int i = 41; i < 45; i++) begin
            free_valid_i = 1; free_preg_i = 6'(i);
            tick();
        end
        alloc_req_i = 1; free_valid_i = 1; free_preg_i = 50;
        tick();
        idle();
        #1 check_eq("t3_count", free_count_o, 5);
        free_valid_i = 1; free_preg_i = 0;
        tick();
        idle();
        #1 check_eq("t3_free0", free_count_o, 5);

        // Save with same-cycle allocation, then recover.
        do_reset();
        alloc_req_i = 1;
        tick(); tick();
        ckpt_save_i = 1;
        #1 check_eq("t4_ckid", ckpt_id_o, 0);
        check_eq("t4_preg34", alloc_preg_o, 34);
        tick();
        ckpt_save_i = 0;
        tick(); tick();
        recover_i = 1; recover_id_i = 0;
        tick();
        idle();
        #1 check_eq("t4_count", free_count_o, 29);
        check_eq("t4_preg35", alloc_preg_o, 35);

        // Fill all checkpoint slots, overflow, release.
        do_reset();
        ckpt_save_i = 1;
        for (int i = 0; i < N_CK; i++) tick();
        #1 check_eq("t5_avail", ckpt_avail_o, 0);
        tick();
        idle();
        #1 check_eq("t5_err", err_o, 1);
        ckpt_release_i = 1;
        tick();
        idle();
        #1 check_eq("t5_avail2", ckpt_avail_o, 1);
        check_eq("t5_ckid", ckpt_id_o, 0);

        // Recover mid-stack with a concurrent free, then asynchronous reset.
        do_reset();
        alloc_req_i = 1; ckpt_save_i = 1;
        tick(); tick(); tick();
        idle();
        recover_i = 1; recover_id_i = 1; alloc_req_i = 1;
        free_valid_i = 1; free_preg_i = 45;
        tick();
        idle();
        #1 check_eq("t6_ckid", ckpt_id_o, 2);
        check_eq("t6_count", free_count_o, 31);
        check_eq("t6_err", err_o, 0);
        alloc_req_i = 1;
        tick();
        idle();
        #2 rst_n = 0;
        #1 check_reset();
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            alloc_req_i = ($urandom_range(0, 9) < 6);
            free_valid_i = ($urandom_range(0, 9) < 4);
            free_preg_i = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            ckpt_save_i = ($urandom_range(0, 9) < 2);
            ckpt_release_i = ($urandom_range(0, 19) < 3);
            recover_i = ($urandom_range(0, 19) == 0);
            recover_id_i = 3'($urandom_range(0, 7));
            // Keep a restore from overcommitting the list beyond its depth.
            if (recover_i && ck_live(int'(recover_id_i), k) &&
                (m_tail + 1 - m_snap[recover_id_i]) > DEPTH) recover_i = 0;
            tick();
            if (n == 1500) begin
                do_reset();
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
